// File: rtl/fetch_port_arbiter_pkg.sv
// Shared definitions for the fetch port arbiter: FSM states, owner ids,
// tag layout and the legal MEM_LAT range.
package fetch_port_arbiter_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_DRAIN = 1'b1
  } arb_state_t;

  typedef logic owner_t;
  localparam owner_t OWN_F1 = 1'b0;
  localparam owner_t OWN_F2 = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 8;
  // Wide enough to hold MEM_LAT_MAX.
  localparam int DRAIN_W = $clog2(MEM_LAT_MAX + 1);

  typedef struct packed {
    logic   vld;
    owner_t own;
  } tag_t;

  function automatic bit lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/fetch_port_arbiter_if.sv
// Bundle of the two fetch request ports, the flush input, the memory read
// port and the busy flag. The arbiter uses the slave modport; the fetch
// units / memory side use master.
interface fetch_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;
  logic              req2;
  logic [ADDR_W-1:0] addr2;
  logic              gnt2;
  logic              rvalid2;
  logic [DATA_W-1:0] rdata2;
  logic              flush;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport master (
    output req1, addr1, req2, addr2, flush, mem_rdata,
    input  gnt1, rvalid1, rdata1, gnt2, rvalid2, rdata2, mem_rd, mem_addr, busy
  );

  modport slave (
    input  req1, addr1, req2, addr2, flush, mem_rdata,
    output gnt1, rvalid1, rdata1, gnt2, rvalid2, rdata2, mem_rd, mem_addr, busy
  );
endinterface

// File: rtl/fetch_port_arbiter_tag_pipe.sv
// fetch_tag_pipe: MEM_LAT-deep {valid, owner} shift register that follows
// each issued read until its data comes back. clr wipes every stage.
module fetch_tag_pipe
  import fetch_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t head,
  output logic any_vld
);

  tag_t [MEM_LAT-1:0] pipe;

  // Shift one stage per cycle; a clear discards everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= clr ? tag_t'('0) : tag_in;
      for (int i = 1; i < MEM_LAT; i++)
        pipe[i] <= clr ? tag_t'('0) : pipe[i-1];
    end
  end

  // Any stage still holding a live read.
  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < MEM_LAT; i++)
      any_vld = any_vld | pipe[i].vld;
  end

  assign head = pipe[MEM_LAT-1];

endmodule

// File: rtl/fetch_port_arbiter.sv
// fetch_port_arbiter: round-robin share of one instruction-memory read port
// between two fetch units, with return-data routing and flush/drain.
// Optional feature macro FETCH_ARB_PERF_EN adds saturating per-requester
// grant counters (grant_cnt1/grant_cnt2).
module fetch_port_arbiter
  import fetch_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  fetch_port_arbiter_if.slave bus
`ifdef FETCH_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]    grant_cnt1,
  output logic [CNT_W-1:0]    grant_cnt2
`endif
);

  if (!lat_ok(MEM_LAT) || CNT_W < 1) begin : g_bad_cfg
    $error("fetch_port_arbiter: MEM_LAT must be 1..8 and CNT_W >= 1");
  end

  arb_state_t         state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt;
  owner_t             last_grant;
  logic               gnt1, gnt2, mem_rd;
  owner_t             gnt_own;
  tag_t               tag_in, head;
  logic               any_vld;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_ARB;
    else       state <= state_nxt;
  end

  // FSM next state: flush always (re)enters drain; drain ends on the last count.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:   if (bus.flush) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!bus.flush && drain_cnt == DRAIN_W'(1)) state_nxt = ST_ARB;
      default:  state_nxt = ST_ARB;
    endcase
  end

  // FSM outputs: combinational round-robin grant, blocked by flush, drain and reset.
  always_comb begin
    logic arb_en;
    arb_en  = (state == ST_ARB) && !bus.flush && !reset;
    gnt1    = arb_en && bus.req1 && (!bus.req2 || last_grant == OWN_F2);
    gnt2    = arb_en && bus.req2 && (!bus.req1 || last_grant == OWN_F1);
    mem_rd  = gnt1 | gnt2;
    gnt_own = gnt2 ? OWN_F2 : OWN_F1;
  end

  // Drain counter covers the full memory latency after the last flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  drain_cnt <= '0;
    else if (bus.flush)         drain_cnt <= DRAIN_W'(MEM_LAT);
    else if (state == ST_DRAIN) drain_cnt <= drain_cnt - DRAIN_W'(1);
  end

  // Round-robin pointer moves only on an actual issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant <= OWN_F2;
    else if (mem_rd) last_grant <= gnt_own;
  end

  assign tag_in = '{vld: mem_rd, own: gnt_own};

  fetch_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .clr     (bus.flush),
    .tag_in  (tag_in),
    .head    (head),
    .any_vld (any_vld)
  );

  // Data arriving in the flush cycle belongs to a discarded read, so mask it.
  always_comb begin
    bus.gnt1     = gnt1;
    bus.gnt2     = gnt2;
    bus.mem_rd   = mem_rd;
    bus.mem_addr = gnt1 ? bus.addr1 : (gnt2 ? bus.addr2 : '0);
    bus.rvalid1  = head.vld && head.own == OWN_F1 && !bus.flush;
    bus.rvalid2  = head.vld && head.own == OWN_F2 && !bus.flush;
    bus.rdata1   = bus.rvalid1 ? bus.mem_rdata : '0;
    bus.rdata2   = bus.rvalid2 ? bus.mem_rdata : '0;
    bus.busy     = (state != ST_ARB) || any_vld;
  end

`ifdef FETCH_ARB_PERF_EN
  // Saturating grant counters; flush does not touch them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt1 <= '0;
      grant_cnt2 <= '0;
    end else begin
      if (gnt1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      if (gnt2 && grant_cnt2 != '1) grant_cnt2 <= grant_cnt2 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_port_arbiter.sv
// Bench for fetch_port_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level model (list of reads in
// flight with due cycles, round-robin owner, drain end cycle).
module tb_fetch_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;
`ifdef FETCH_ARB_PERF_EN
  localparam int CNT_W   = 4;
`else
  localparam int CNT_W   = 16;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef FETCH_ARB_PERF_EN
  logic [CNT_W-1:0] grant_cnt1, grant_cnt2;
`endif

  fetch_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_ARB_PERF_EN
    ,
    .grant_cnt1 (grant_cnt1),
    .grant_cnt2 (grant_cnt2)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: each issued read becomes an entry due MEM_LAT cycles later.
  typedef struct { int due; int own; } flight_t;
  flight_t q[$];
  int cyc, resume, last, gc1, gc2;
  bit e_g1, e_g2;
  bit obs_g1;
  logic [5:0] gseq;
  bit p1, p2, rfl;
  logic [31:0] ra1, ra2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cyc = 0; resume = 0; last = 2; gc1 = 0; gc2 = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req1 = 0; bus.req2 = 0; bus.flush = 0;
    repeat (2) @(posedge clk);
    model_reset();
  endtask

  // One clock: drive inputs just after the edge, check mid-cycle, advance model.
  task automatic step(input logic r1, input logic [31:0] a1, input logic r2,
                      input logic [31:0] a2, input logic fl);
    logic [31:0] md, e_addr, e_d1, e_d2;
    bit e_v1, e_v2, e_busy;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req1 = r1; bus.addr1 = a1; bus.req2 = r2; bus.addr2 = a2; bus.flush = fl;
    md = $urandom; bus.mem_rdata = md;
    #4;
    e_g1 = 0; e_g2 = 0;
    if (cyc >= resume && !fl) begin
      if (r1 && (!r2 || last == 2)) e_g1 = 1;
      else if (r2)                  e_g2 = 1;
    end
    e_addr = e_g1 ? a1 : (e_g2 ? a2 : 32'h0);
    e_v1 = 0; e_v2 = 0; e_busy = (cyc < resume);
    foreach (q[i]) begin
      if (q[i].due == cyc && !fl) begin
        if (q[i].own == 1) e_v1 = 1; else e_v2 = 1;
      end
      if (q[i].due >= cyc) e_busy = 1;
    end
    e_d1 = e_v1 ? md : 32'h0;
    e_d2 = e_v2 ? md : 32'h0;
    obs_g1 = bus.gnt1;
    chk("gnt1",     64'(bus.gnt1),     64'(e_g1));
    chk("gnt2",     64'(bus.gnt2),     64'(e_g2));
    chk("mem_rd",   64'(bus.mem_rd),   64'(e_g1 | e_g2));
    chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
    chk("rvalid1",  64'(bus.rvalid1),  64'(e_v1));
    chk("rvalid2",  64'(bus.rvalid2),  64'(e_v2));
    chk("rdata1",   64'(bus.rdata1),   64'(e_d1));
    chk("rdata2",   64'(bus.rdata2),   64'(e_d2));
    chk("busy",     64'(bus.busy),     64'(e_busy));
    if (e_g1) begin q.push_back('{cyc + MEM_LAT, 1}); last = 1; gc1++; end
    if (e_g2) begin q.push_back('{cyc + MEM_LAT, 2}); last = 2; gc2++; end
    if (fl) begin
      q.delete();
      resume = cyc + MEM_LAT + 1;
    end else begin
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    end
    cyc++;
  endtask

  initial begin
    reset = 1'b1;
    bus.req1 = 0; bus.addr1 = 0; bus.req2 = 0; bus.addr2 = 0;
    bus.flush = 0; bus.mem_rdata = 32'hdead_beef;
    #1;
    chk("rst_gnt1",   64'(bus.gnt1),    64'h0);
    chk("rst_mem_rd", 64'(bus.mem_rd),  64'h0);
    chk("rst_rvalid", 64'(bus.rvalid1 | bus.rvalid2), 64'h0);
    chk("rst_busy",   64'(bus.busy),    64'h0);
    do_reset();

    // 1: single read from fetch 1, data back two cycles later.
    step(1, 32'h4, 0, 0, 0);
    chk("t1_addr", 64'(bus.mem_addr), 64'h4);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t1_rvalid1", 64'(bus.rvalid1), 64'h1);
    step(0, 0, 0, 0, 0);

    // 2: both requesting for 6 cycles alternates starting with fetch 1.
    do_reset();
    gseq = '0;
    for (int i = 0; i < 6; i++) begin
      step(1, 32'h100 + i, 1, 32'h200 + i, 0);
      gseq = {gseq[4:0], obs_g1};
    end
    chk("t2_order", 64'(gseq), 64'(6'b101010));
    repeat (3) step(0, 0, 0, 0, 0);

    // 3: flush with two reads in flight; grants resume on the 4th cycle.
    do_reset();
    step(1, 32'h40, 0, 0, 0);
    step(0, 0, 1, 32'h80, 0);
    step(1, 32'h44, 1, 32'h84, 1);
    chk("t3_flush_busy", 64'(bus.busy), 64'h1);
    step(1, 32'h44, 1, 32'h84, 0);
    chk("t3_drain_rv2", 64'(bus.rvalid2), 64'h0);
    step(1, 32'h44, 1, 32'h84, 0);
    chk("t3_drain_busy", 64'(bus.busy), 64'h1);
    step(1, 32'h44, 1, 32'h84, 0);
    chk("t3_resume", 64'(bus.gnt1), 64'h1);
    repeat (3) step(0, 0, 0, 0, 0);

    // 4: asynchronous reset with reads in flight and both requesting.
    step(1, 32'h10, 1, 32'h20, 0);
    step(1, 32'h14, 1, 32'h20, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("t4_gnt",    64'(bus.gnt1 | bus.gnt2),       64'h0);
    chk("t4_mem_rd", 64'(bus.mem_rd),                64'h0);
    chk("t4_rvalid", 64'(bus.rvalid1 | bus.rvalid2), 64'h0);
    chk("t4_busy",   64'(bus.busy),                  64'h0);
    do_reset();
    step(1, 32'h30, 1, 32'h34, 0);
    chk("t4_first", 64'(bus.gnt1), 64'h1);
    repeat (4) step(0, 0, 0, 0, 0);

    // 5: req2 alone twice, then both held -> 2,2,1,2,1.
    do_reset();
    gseq = '0;
    step(0, 0, 1, 32'h500, 0); gseq = {gseq[4:0], obs_g1};
    step(0, 0, 1, 32'h504, 0); gseq = {gseq[4:0], obs_g1};
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h600, 1, 32'h508, 0);
      gseq = {gseq[4:0], obs_g1};
    end
    chk("t5_order", 64'(gseq[4:0]), 64'(5'b00101));
    repeat (3) step(0, 0, 0, 0, 0);

    // Random traffic: requesters hold until granted, occasional flush.
    p1 = 0; p2 = 0; ra1 = 0; ra2 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!p1 && $urandom_range(1, 0) == 1) begin p1 = 1; ra1 = $urandom; end
      if (!p2 && $urandom_range(1, 0) == 1) begin p2 = 1; ra2 = $urandom; end
      rfl = ($urandom_range(15, 0) == 0);
      step(p1, ra1, p2, ra2, rfl);
      if (e_g1) p1 = 0;
      if (e_g2) p2 = 0;
    end
    repeat (4) step(0, 0, 0, 0, 0);

`ifdef FETCH_ARB_PERF_EN
    // 6: 20 grants to fetch 1 saturate a 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 32'h1000 + 4 * i, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_cnt1", 64'(grant_cnt1), 64'd15);
    chk("t6_cnt2", 64'(grant_cnt2), 64'(gc2 > 15 ? 15 : gc2));
    chk("t6_cnt1_model", 64'(grant_cnt1), 64'(gc1 > 15 ? 15 : gc1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
